fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 110 +++++++++++
 tb/tb_fetch_queue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - show-ahead instruction queue between fetch and decode
//
// Purpose: small FIFO of {instr, pc} pairs. The head entry is presented to
// decode combinationally from registered state (no read latency); a NOP
// bubble with pc 0 is presented whenever the queue is empty.
//
// Ports:
//   c_clk        clock, all state updates on the rising edge
//   c_rst        asynchronous active-high reset (pointers and count only)
//   fq_i_flush   discard all queued entries; wins over push and pop
//   fq_i_valid   fetch presents fq_i_instr / fq_i_pc
//   fq_i_instr   fetched instruction word
//   fq_i_pc      PC of the fetched instruction
//   fq_o_ready   queue can accept a push (not full)
//   fq_o_valid   head entry valid for decode (not empty)
//   fq_o_instr   head instruction, NOP_INSTR when empty
//   fq_o_pc      head PC, 0 when empty
//   fq_i_ready   decode consumes the head this cycle
//   fq_o_count   occupied entries, 0..DEPTH
//   fq_o_full    count == DEPTH
//   fq_o_empty   count == 0

module fetch_queue #(
  parameter int                IWIDTH    = 32,
  parameter int                PC_WIDTH  = 32,
  parameter int                DEPTH     = 4,
  parameter logic [IWIDTH-1:0] NOP_INSTR = IWIDTH'(32'h00000013)
) (
  input  logic                       c_clk,
  input  logic                       c_rst,
  input  logic                       fq_i_flush,
  input  logic                       fq_i_valid,
  input  logic [IWIDTH-1:0]          fq_i_instr,
  input  logic [PC_WIDTH-1:0]        fq_i_pc,
  output logic                       fq_o_ready,
  output logic                       fq_o_valid,
  output logic [IWIDTH-1:0]          fq_o_instr,
  output logic [PC_WIDTH-1:0]        fq_o_pc,
  input  logic                       fq_i_ready,
  output logic [$clog2(DEPTH):0]     fq_o_count,
  output logic                       fq_o_full,
  output logic                       fq_o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Storage is deliberately left out of reset/flush; only the pointers and
  // the count define which entries are live.
  logic [IWIDTH-1:0]   instr_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic push;
  logic pop;

  // Status flags come straight from the count register, so there is no
  // combinational path from any input to any output.
  assign fq_o_full  = (count == CW'(DEPTH));
  assign fq_o_empty = (count == '0);
  assign fq_o_ready = !fq_o_full;
  assign fq_o_valid = !fq_o_empty;
  assign fq_o_count = count;

  // Push is gated by ready, so a push while full is refused even when a pop
  // frees a slot in the same cycle.
  assign push = fq_i_valid && fq_o_ready && !fq_i_flush;
  assign pop  = fq_o_valid && fq_i_ready && !fq_i_flush;

  // Show-ahead head: mask with the bubble when empty so stale storage never
  // leaks out after a flush or reset.
  assign fq_o_instr = fq_o_empty ? NOP_INSTR      : instr_mem[rd_ptr];
  assign fq_o_pc    = fq_o_empty ? '0             : pc_mem[rd_ptr];

  always_ff @(posedge c_clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= fq_i_instr;
      pc_mem[wr_ptr]    <= fq_i_pc;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally on overflow.
  always_ff @(posedge c_clk or posedge c_rst) begin
    if (c_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (fq_i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue

module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        c_clk;
  logic        c_rst;
  logic        fq_i_flush;
  logic        fq_i_valid;
  logic [31:0] fq_i_instr;
  logic [31:0] fq_i_pc;
  logic        fq_o_ready;
  logic        fq_o_valid;
  logic [31:0] fq_o_instr;
  logic [31:0] fq_o_pc;
  logic        fq_i_ready;
  logic [2:0]  fq_o_count;
  logic        fq_o_full;
  logic        fq_o_empty;

  fetch_queue #(
    .IWIDTH   (32),
    .PC_WIDTH (32),
    .DEPTH    (DEPTH),
    .NOP_INSTR(32'h00000013)
  ) dut (
    .c_clk      (c_clk),
    .c_rst      (c_rst),
    .fq_i_flush (fq_i_flush),
    .fq_i_valid (fq_i_valid),
    .fq_i_instr (fq_i_instr),
    .fq_i_pc    (fq_i_pc),
    .fq_o_ready (fq_o_ready),
    .fq_o_valid (fq_o_valid),
    .fq_o_instr (fq_o_instr),
    .fq_o_pc    (fq_o_pc),
    .fq_i_ready (fq_i_ready),
    .fq_o_count (fq_o_count),
    .fq_o_full  (fq_o_full),
    .fq_o_empty (fq_o_empty)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  typedef struct {
    logic        flush;
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    int          exp_count;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  vec_t   vecs[$];
  entry_t sb[$];
  int     total = 0;
  int     bad   = 0;

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return (pc * 32'd3) ^ 32'h0BAD_F00D;
  endfunction

  function automatic void add(input logic f, input logic v, input logic r,
                              input logic [31:0] pc, input int c);
    vec_t x;
    x.flush = f; x.valid = v; x.ready = r; x.pc = pc; x.exp_count = c;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Compare all status and head outputs with the scoreboard contents.
  task automatic check_outputs(input string tag);
    chk({tag, "_count"}, 64'(fq_o_count), 64'(sb.size()));
    chk({tag, "_empty"}, 64'(fq_o_empty), 64'(sb.size() == 0));
    chk({tag, "_full"},  64'(fq_o_full),  64'(sb.size() == DEPTH));
    chk({tag, "_valid"}, 64'(fq_o_valid), 64'(sb.size() != 0));
    chk({tag, "_ready"}, 64'(fq_o_ready), 64'(sb.size() != DEPTH));
    if (sb.size() != 0) begin
      chk({tag, "_head_pc"},    64'(fq_o_pc),    64'(sb[0].pc));
      chk({tag, "_head_instr"}, 64'(fq_o_instr), 64'(sb[0].instr));
    end else begin
      chk({tag, "_nop_pc"},    64'(fq_o_pc),    64'h0);
      chk({tag, "_nop_instr"}, 64'(fq_o_instr), 64'h13);
    end
  endtask

  task automatic step(input logic f, input logic v, input logic r,
                      input logic [31:0] p, input int exp_cnt, input string tag);
    logic   do_push;
    logic   do_pop;
    entry_t e;
    @(negedge c_clk);
    fq_i_flush = f;
    fq_i_valid = v;
    fq_i_ready = r;
    fq_i_pc    = p;
    fq_i_instr = mk_instr(p);
    #1;
    do_push = v && !f && (sb.size() < DEPTH);
    do_pop  = r && !f && (sb.size() > 0);
    if (do_pop) begin
      e = sb.pop_front();
      chk({tag, "_pop_pc"},    64'(fq_o_pc),    64'(e.pc));
      chk({tag, "_pop_instr"}, 64'(fq_o_instr), 64'(e.instr));
    end
    if (f) sb.delete();
    if (do_push) begin
      e.pc = p;
      e.instr = mk_instr(p);
      sb.push_back(e);
    end
    @(posedge c_clk);
    #1;
    chk({tag, "_tbl_count"}, 64'(fq_o_count), 64'(exp_cnt));
    check_outputs(tag);
  endtask

  task automatic idle();
    fq_i_flush = 1'b0;
    fq_i_valid = 1'b0;
    fq_i_ready = 1'b0;
    fq_i_pc    = '0;
    fq_i_instr = '0;
  endtask

  logic [31:0] held_pc;
  logic [31:0] held_instr;

  initial begin
    idle();
    c_rst = 1'b1;

    // Fill with decode stalled, refused push when full, then drain in order.
    add(0, 1, 0, 32'd0,  1);
    add(0, 1, 0, 32'd4,  2);
    add(0, 1, 0, 32'd8,  3);
    add(0, 1, 0, 32'd12, 4);
    add(0, 1, 0, 32'd16, 4);
    add(0, 0, 1, 32'd0,  3);
    add(0, 0, 1, 32'd0,  2);
    add(0, 0, 1, 32'd0,  1);
    add(0, 0, 1, 32'd0,  0);
    add(0, 0, 1, 32'd0,  0);
    // Steady push+pop at count 2 across pointer wrap.
    add(0, 1, 0, 32'h200, 1);
    add(0, 1, 0, 32'h204, 2);
    for (int i = 0; i < 10; i++) add(0, 1, 1, 32'h208 + 32'(4 * i), 2);
    add(0, 0, 1, 32'd0, 1);
    add(0, 0, 1, 32'd0, 0);
    // Full edge: pop taken, push refused.
    add(0, 1, 0, 32'h300, 1);
    add(0, 1, 0, 32'h304, 2);
    add(0, 1, 0, 32'h308, 3);
    add(0, 1, 0, 32'h30C, 4);
    add(0, 1, 1, 32'h310, 3);
    // Flush priority with coincident push and pop at count 3.
    add(1, 1, 1, 32'h400, 0);
    add(0, 0, 1, 32'd0,   0);
    // Push while empty with ready high: no pop that cycle.
    add(0, 1, 1, 32'h500, 1);
    add(0, 0, 1, 32'd0,   0);

    #12;
    chk("rst_count", 64'(fq_o_count), 64'h0);
    chk("rst_empty", 64'(fq_o_empty), 64'h1);
    chk("rst_full",  64'(fq_o_full),  64'h0);
    chk("rst_valid", 64'(fq_o_valid), 64'h0);
    chk("rst_ready", 64'(fq_o_ready), 64'h1);
    chk("rst_instr", 64'(fq_o_instr), 64'h13);
    chk("rst_pc",    64'(fq_o_pc),    64'h0);
    @(negedge c_clk);
    c_rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].flush, vecs[i].valid, vecs[i].ready, vecs[i].pc,
           vecs[i].exp_count, $sformatf("v%0d", i));
    end

    // Stall hold: one entry, decode stalled for 5 cycles.
    step(0, 1, 0, 32'h600, 1, "hold_push");
    held_pc    = fq_o_pc;
    held_instr = fq_o_instr;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 32'hDEAD_0000, 1, $sformatf("hold%0d", i));
      chk("hold_pc_stable",    64'(fq_o_pc),    64'h600);
      chk("hold_instr_stable", 64'(fq_o_instr), 64'(mk_instr(32'h600)));
      chk("hold_valid",        64'(fq_o_valid), 64'h1);
    end
    step(0, 0, 1, 32'd0, 0, "hold_pop");

    // Asynchronous reset between edges with two entries queued.
    step(0, 1, 0, 32'h700, 1, "ar_push0");
    step(0, 1, 0, 32'h704, 2, "ar_push1");
    @(negedge c_clk);
    idle();
    #2;
    c_rst = 1'b1;
    #1;
    sb.delete();
    chk("ar_count", 64'(fq_o_count), 64'h0);
    chk("ar_valid", 64'(fq_o_valid), 64'h0);
    chk("ar_ready", 64'(fq_o_ready), 64'h1);
    chk("ar_empty", 64'(fq_o_empty), 64'h1);
    chk("ar_instr", 64'(fq_o_instr), 64'h13);
    chk("ar_pc",    64'(fq_o_pc),    64'h0);
    @(negedge c_clk);
    c_rst = 1'b0;
    step(0, 1, 0, 32'h100, 1, "ar_post");
    chk("ar_post_pc", 64'(fq_o_pc), 64'h100);
    step(0, 0, 1, 32'd0, 0, "ar_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
